// File: rtl/key_sched_ctrl.sv
// AES-128 key-schedule sequencer: one ke_core round per clock fills an
// 11-entry round-key register file that the cipher datapath reads combinationally.

module ke_core (
    input  logic [127:0] word_in,
    input  logic [7:0]   i,
    output logic [127:0] word_out
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // S-box built from the field inverse (x^254, which maps 0 to 0) plus the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int n = 1; n < 8; n++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, temp;
    logic [31:0] n0, n1, n2, n3;
    logic [7:0]  rcon;

    always_comb begin
        unique case (i)
            8'd1:    rcon = 8'h01;
            8'd2:    rcon = 8'h02;
            8'd3:    rcon = 8'h04;
            8'd4:    rcon = 8'h08;
            8'd5:    rcon = 8'h10;
            8'd6:    rcon = 8'h20;
            8'd7:    rcon = 8'h40;
            8'd8:    rcon = 8'h80;
            8'd9:    rcon = 8'h1b;
            8'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign {w0, w1, w2, w3} = word_in;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sub
        assign sub[gi*8 +: 8] = sbox(rot[gi*8 +: 8]);
    end

    assign temp = sub ^ {rcon, 24'h000000};
    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign word_out = {n0, n1, n2, n3};
endmodule

module key_sched_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data
);
    localparam logic [3:0] LAST_RND = 4'(NR);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t       state_reg, state_next;
    logic [3:0]   rnd_reg, rnd_next;
    logic         keys_valid_reg, keys_valid_next;
    logic         done_reg, done_next;
    logic         load_key, wr_en;
    logic [127:0] rk_reg [0:NR];
    logic [127:0] ke_out;

    ke_core u_ke_core (
        .word_in  (rk_reg[rnd_reg - 4'd1]),
        .i        ({4'b0000, rnd_reg}),
        .word_out (ke_out)
    );

    always_comb begin
        state_next      = state_reg;
        rnd_next        = rnd_reg;
        keys_valid_next = keys_valid_reg;
        done_next       = 1'b0;
        load_key        = 1'b0;
        wr_en           = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    load_key        = 1'b1;
                    rnd_next        = 4'd1;
                    keys_valid_next = 1'b0;
                    state_next      = EXPAND;
                end
            end
            EXPAND: begin
                wr_en = 1'b1;
                if (rnd_reg == LAST_RND) begin
                    keys_valid_next = 1'b1;
                    done_next       = 1'b1;
                    state_next      = IDLE;
                end else begin
                    rnd_next = rnd_reg + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rnd_reg        <= 4'd1;
            keys_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rnd_reg        <= rnd_next;
            keys_valid_reg <= keys_valid_next;
            done_reg       <= done_next;
        end
    end

    // Entries are never cleared on restart; each is simply overwritten in round order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NR; k++) rk_reg[k] <= '0;
        end else begin
            if (load_key) rk_reg[0] <= key_in;
            if (wr_en) rk_reg[rnd_reg] <= ke_out;
        end
    end

    always_comb begin
        rk_data = '0;
        for (int k = 0; k <= NR; k++) begin
            if (rk_addr == 4'(k)) rk_data = rk_reg[k];
        end
    end

    assign busy       = (state_reg == EXPAND);
    assign done       = done_reg;
    assign keys_valid = keys_valid_reg;
endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl using FIPS-197 and all-zero key schedules.

module tb_key_sched_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy, done, keys_valid;
    logic [3:0]   rk_addr = 4'd0;
    logic [127:0] rk_data;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK2 = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] ALT_KEY = 128'hffffffffffffffffffffffffffffffff;

    key_sched_ctrl #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [3:0] addr, input logic [127:0] exp);
        rk_addr = addr;
        #1;
        chk(tag, rk_data, exp);
    endtask

    // Start an expansion; returns the cycle count to done (-1 on timeout)
    // and keys_valid as seen right after the accepting edge.
    task automatic run_key(input logic [127:0] key, input bit pulse,
                           input logic [127:0] alt, output int lat, output logic kv_first);
        @(negedge clk);
        key_in = key;
        start  = 1'b1;
        lat = -1;
        kv_first = 1'bx;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start  = pulse && (k == 3 || k == 7);
            key_in = pulse ? alt : key;
            if (k == 1) kv_first = keys_valid;
            if (done) begin
                lat = k;
                break;
            end
            chk($sformatf("busy_c%0d", k), busy, 1);
        end
        start = 1'b0;
        chk("latency", lat, 11);
        chk("busy_at_done", busy, 0);
        chk("kv_at_done", keys_valid, 1);
        $display("expansion key=%h latency=%0d", key, lat);
    endtask

    int   lat;
    logic kv_first;

    initial begin
        // Reset values and full address sweep.
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_kv", keys_valid, 0);
        for (int a = 0; a < 16; a++) rd($sformatf("rst_rk%0d", a), 4'(a), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 key.
        run_key(FIPS_KEY, 1'b0, '0, lat, kv_first);
        rd("fips_rk0", 4'd0, FIPS_KEY);
        rd("fips_rk1", 4'd1, FIPS_RK1);
        rd("fips_rk2", 4'd2, FIPS_RK2);
        rd("fips_rk10", 4'd10, FIPS_RK10);
        rd("fips_rk11", 4'd11, '0);
        rd("fips_rk15", 4'd15, '0);

        // Back-to-back all-zero key.
        run_key('0, 1'b0, '0, lat, kv_first);
        chk("b2b_kv_drop", kv_first, 0);
        rd("zero_rk0", 4'd0, '0);
        rd("zero_rk1", 4'd1, ZERO_RK1);
        rd("zero_rk10", 4'd10, ZERO_RK10);
        @(negedge clk);
        chk("done_one_cycle", done, 0);

        // Start pulses mid-expansion with a different key must be ignored.
        run_key(FIPS_KEY, 1'b1, ALT_KEY, lat, kv_first);
        rd("ign_rk0", 4'd0, FIPS_KEY);
        rd("ign_rk1", 4'd1, FIPS_RK1);
        rd("ign_rk10", 4'd10, FIPS_RK10);
        @(negedge clk);
        chk("ign_no_restart", busy, 0);

        // Reset during round 5.
        @(negedge clk);
        key_in = ALT_KEY;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_kv", keys_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int done_seen = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (done) done_seen++;
            end
            chk("abort_no_done", done_seen, 0);
        end
        chk("abort_kv_after", keys_valid, 0);
        for (int a = 0; a <= 10; a++) rd($sformatf("abort_rk%0d", a), 4'(a), '0);
        run_key(FIPS_KEY, 1'b0, '0, lat, kv_first);
        rd("post_rk1", 4'd1, FIPS_RK1);
        rd("post_rk10", 4'd10, FIPS_RK10);

        // start held high continuously.
        @(negedge clk);
        key_in = '0;
        start  = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            chk($sformatf("hold_done_c%0d", k), done, (k % 11 == 0));
            chk($sformatf("hold_busy_c%0d", k), busy, (k % 11 != 0));
            chk($sformatf("hold_kv_c%0d", k), keys_valid, (k % 11 == 0));
        end
        start = 1'b0;
        rd("hold_rk10", 4'd10, ZERO_RK10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

Sequencing controller for the combinational key-expansion round `ke_core`. On a start request it captures a 128-bit AES cipher key, iterates one internal `ke_core` instance over rounds 1..10 at one round per clock, and stores all 11 round keys in a register file. The cipher datapath reads the keys through a combinational read port. It sits between key loading, which drives `start` and `key_in`, and the AES round datapath, which reads `rk_addr` and `rk_data`.

## Interface
Parameters:
- `NR`, default 10: number of expansion rounds. Only 10 (AES-128) is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request expansion of `key_in`. Sampled only in IDLE.
- `key_in`  in  128  cipher key. Sampled on the cycle `start` is accepted.
- `busy`  out  1  high while expansion is in progress (state EXPAND).
- `done`  out  1  single-cycle pulse after round key 10 is written.
- `keys_valid`  out  1  all 11 round keys are valid and stable.
- `rk_addr`  in  4  round-key index, 0..10.
- `rk_data`  out  128  combinational read of `rk[rk_addr]`. Returns 0 when `rk_addr` > 10.

## Operation
- Storage: `rk[0..10]`, 128 bits each. A 4-bit round counter `rnd` holds values 1..10.
- `ke_core` instance connections:
  - `word_in` = `rk[rnd-1]`
  - `i` = {4'b0, `rnd`}
  - `word_out` is the next round key.
- The FSM has two states, IDLE and EXPAND.
- IDLE with `start`=1:
  - `rk[0]` <= `key_in`, `rnd` <= 1, `keys_valid` <= 0.
  - Next state is EXPAND.
- IDLE with `start`=0: hold all state.
- EXPAND, every cycle: `rk[rnd]` <= `ke_core.word_out`.
  - If `rnd` < 10: `rnd` <= `rnd`+1 and stay in EXPAND.
  - If `rnd` == 10: `keys_valid` <= 1, `done` <= 1 for one cycle, next state IDLE.
- `start` during EXPAND is ignored. It is not queued, and `key_in` is not sampled.
- `start` in IDLE while `keys_valid`=1 restarts expansion with the new key. `keys_valid` drops on the accepting edge.
- Reads during EXPAND return the current register contents, which may be partially updated or stale. Consumers must qualify reads with `keys_valid`.
- `rk` entries are not cleared on restart. Each is overwritten in order.

## Timing
- Reset (`rst_n`=0, asynchronous) forces:
  - state = IDLE
  - `busy`=0, `done`=0, `keys_valid`=0
  - `rnd`=1
  - all `rk` entries = 0
  - `rk_data` therefore reads 0.
- Reset during EXPAND aborts immediately. No `done` pulse is produced, and `keys_valid` stays 0 after `rst_n` is released.
- Let edge E0 be the edge that accepts `start`:
  - `busy`=1 from after E0 through E10.
  - Edges E1..E10 write `rk[1]`..`rk[10]`.
  - After E10, `busy`=0 and `done`=1 for exactly one cycle, and `keys_valid`=1.
  - Total latency from `start` accepted to `done` is 11 cycles.
- `start` held high continuously: expansion restarts on the first IDLE cycle, which is the cycle where `done`=1. That cycle's `start` is accepted, so `keys_valid` goes high and then drops on the next edge.
- `busy` and `done` are never high in the same cycle.
- `rk_data` is purely combinational from `rk_addr` and storage, with no added latency.

## Test plan
- FIPS-197 key, `key_in`=2b7e151628aed2a6abf7158809cf4f3c, one-cycle `start`. Required response:
  - `done` appears exactly 11 cycles after the accepting edge.
  - `rk[1]`=a0fafe1788542cb123a339392a6c7605
  - `rk[2]`=f2c295f27a96b9435935807a7359f67f
  - `rk[10]`=d014f9a8c9ee2589e13f0cc8b6630ca6
  - `rk[0]`=key.
- Reset values: assert `rst_n`=0, then sweep `rk_addr` 0..15. Required: all reads are 0, `busy`/`done`/`keys_valid` are 0, and `rk_addr`=11..15 always return 0.
- `start` pulsed at cycles 3 and 7 of an expansion with a different `key_in`. Required: both ignored, and the final keys match the first key's schedule.
- Back-to-back keys: after `done`, start an all-zero key. Required:
  - `keys_valid` drops on the accepting edge.
  - `rk[1]`=62636363626363636263636362636363
  - `rk[10]`=b4ef5bcb3e92e21123e951cf6f8f188e.
- Reset mid-expansion: deassert `rst_n` at round 5, release it, then wait 20 cycles. Required: no `done`, `keys_valid`=0, `rk` all 0, and a subsequent `start` completes normally.
- `start` held high permanently. Required: `done` pulses every 11 cycles, `busy` low only on the `done` cycles, and `keys_valid` high only during the `done` cycles.
